// File: rtl/branch_comp_if.sv
// Operand/decision bundle between the execute stage and the branch comparator.
// taken_cnt exists only when BRANCH_COMP_STATS_EN is defined.
interface branch_comp_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      funct3;
  logic            branch;
  logic            branch_q;
  logic            illegal;
`ifdef BRANCH_COMP_STATS_EN
  logic [31:0]     taken_cnt;
`endif

  modport master (
    output op1, op2, funct3,
    input  branch, branch_q, illegal
`ifdef BRANCH_COMP_STATS_EN
    , input taken_cnt
`endif
  );

  modport slave (
    input  op1, op2, funct3,
    output branch, branch_q, illegal
`ifdef BRANCH_COMP_STATS_EN
    , output taken_cnt
`endif
  );
endinterface

// File: rtl/branch_comp.sv
// RV32I branch comparator: branch/illegal combinational (0 cycles), branch_q 1 cycle; no backpressure.
// Optional taken-branch counter enabled by BRANCH_COMP_STATS_EN.
module branch_comp #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  branch_comp_if.slave   bus
);

  logic branch;
  logic illegal;

  // Encodings 010/011 are reserved: never taken, flagged for trace.
  always_comb begin
    branch  = 1'b0;
    illegal = 1'b0;
    case (bus.funct3)
      3'b000:  branch = (bus.op1 == bus.op2);
      3'b001:  branch = (bus.op1 != bus.op2);
      3'b100:  branch = ($signed(bus.op1) <  $signed(bus.op2));
      3'b101:  branch = ($signed(bus.op1) >= $signed(bus.op2));
      3'b110:  branch = (bus.op1 <  bus.op2);
      3'b111:  branch = (bus.op1 >= bus.op2);
      default: illegal = 1'b1;
    endcase
  end

  assign bus.branch  = branch;
  assign bus.illegal = illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.branch_q <= 1'b0;
    end else begin
      bus.branch_q <= branch;
    end
  end

`ifdef BRANCH_COMP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.taken_cnt <= 32'd0;
    end else if (branch && !illegal) begin
      bus.taken_cnt <= bus.taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_comp.sv
// Scoreboard bench for branch_comp: directed boundary vectors plus random traffic vs. an arithmetic model.
module tb_branch_comp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_comp_if #(.XLEN(32)) bif();

  branch_comp #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        exp_branch;
    logic        exp_illegal;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic stim_vld = 1'b0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: operands interpreted as mathematical integers.
  function automatic longint as_signed(input logic [31:0] v);
    longint u = longint'(v);
    return v[31] ? u - 64'sd4294967296 : u;
  endfunction

  function automatic logic [1:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    longint sa = as_signed(a), sb = as_signed(b);
    longint ua = longint'(a), ub = longint'(b);
    case (f)
      3'd0: return {1'b0, ua == ub};
      3'd1: return {1'b0, ua != ub};
      3'd4: return {1'b0, sa <  sb};
      3'd5: return {1'b0, sa >= sb};
      3'd6: return {1'b0, ua <  ub};
      3'd7: return {1'b0, ua >= ub};
      default: return 2'b10;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    bif.op1 = a;
    bif.op2 = b;
    bif.funct3 = f;
  endtask

  // Each vector is held for exactly one rising edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    exp_t e;
    logic [1:0] m;
    @(posedge clk);
    #2;
    drive(a, b, f);
    m = model(a, b, f);
    e.a = a; e.b = b; e.f = f;
    e.exp_illegal = m[1];
    e.exp_branch  = m[0];
    if (m[0]) exp_cnt = exp_cnt + 32'd1;
    q.push_back(e);
    stim_vld = 1'b1;
  endtask

  // Monitor: combinational outputs mid-cycle, then the registered copy after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stim_vld) begin
        if (q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("branch f=%0d a=%h b=%h", e.f, e.a, e.b), {31'd0, bif.branch}, {31'd0, e.exp_branch});
          chk($sformatf("illegal f=%0d", e.f), {31'd0, bif.illegal}, {31'd0, e.exp_illegal});
          @(posedge clk);
          #1;
          chk($sformatf("branch_q f=%0d a=%h b=%h", e.f, e.a, e.b), {31'd0, bif.branch_q}, {31'd0, e.exp_branch});
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [31:0] edge_vals [6];
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h8000_0000; edge_vals[3] = 32'h7FFF_FFFF;
    edge_vals[4] = 32'h0000_0001; edge_vals[5] = 32'hFFFF_FFFE;

    // Register path: held at 0 under reset even with a taken branch presented.
    drive(32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000);
    @(posedge clk); #1;
    chk("branch_q_in_reset", {31'd0, bif.branch_q}, 32'd0);
`ifdef BRANCH_COMP_STATS_EN
    chk("taken_cnt_in_reset", bif.taken_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("branch_q_after_release", {31'd0, bif.branch_q}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("branch_q_async_reset", {31'd0, bif.branch_q}, 32'd0);
    @(posedge clk); #1;
    chk("branch_q_held_in_reset", {31'd0, bif.branch_q}, 32'd0);

    // Counter: 3 taken edges, then 2 not-taken edges.
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    drive(32'hB6B6_B6B6, 32'hB6B6_B6B6, 3'b001);
    repeat (2) @(posedge clk);
    #1;
`ifdef BRANCH_COMP_STATS_EN
    chk("taken_cnt_3_of_5", bif.taken_cnt, 32'd3);
`endif
    chk("branch_q_not_taken", {31'd0, bif.branch_q}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
`ifdef BRANCH_COMP_STATS_EN
    chk("taken_cnt_async_reset", bif.taken_cnt, 32'd0);
`endif
    drive(32'h0, 32'h0, 3'b010);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;

    // Directed vectors and boundaries.
    apply(32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000);
    apply(32'hA5A5_A5A5, 32'hB5B5_B5B5, 3'b000);
    apply(32'hB6B6_B6B6, 32'hB6B6_B6B6, 3'b001);
    apply(-32'sd10, -32'sd5, 3'b100);
    apply(32'd2, -32'sd5, 3'b100);
    apply(-32'sd5, -32'sd10, 3'b101);
    apply(-32'sd20, -32'sd10, 3'b101);
    apply(32'd1, 32'hFFFF_FFFF, 3'b110);
    apply(32'hFFFF_FFFF, 32'd1, 3'b110);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);
    apply(32'd1, 32'hFFFF_FFFF, 3'b111);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 3'b100);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 3'b110);
    apply(32'hFFFF_FFFF, 32'h0, 3'b100);
    apply(32'hFFFF_FFFF, 32'h0, 3'b111);
    apply(32'h1234_5678, 32'h1234_5678, 3'b010);
    apply(32'hDEAD_BEEF, 32'h0000_0001, 3'b011);
    for (int f = 0; f < 8; f++) apply(32'h5A5A_0F0F, 32'h5A5A_0F0F, 3'(f));

    // Random traffic, biased toward equal and edge operands.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = edge_vals[$urandom_range(0, 5)]; b = edge_vals[$urandom_range(0, 5)]; end
        1: begin a = $urandom; b = a; end
        2: begin a = $urandom; b = a ^ (32'd1 << $urandom_range(0, 31)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      apply(a, b, 3'($urandom_range(0, 7)));
    end

    @(posedge clk);
    #2;
    stim_vld = 1'b0;
    drive(32'h0, 32'h0, 3'b010);
    repeat (3) @(posedge clk);
    #1;
`ifdef BRANCH_COMP_STATS_EN
    chk("taken_cnt_random", bif.taken_cnt, exp_cnt);
`endif
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
